// File: rtl/rle_pkg.sv
// RLE encoder shared types: run record layout and run-length limit.
// Record fields are sized to the widest supported value/length.
package rle_pkg;

  localparam int VAL_W_MAX = 16;
  localparam int LEN_W_MAX = 16;

  typedef struct packed {
    logic [VAL_W_MAX-1:0] value;
    logic [LEN_W_MAX-1:0] length;
    logic                 eol;
  } rle_rec_t;

  function automatic int unsigned run_max(
    input int unsigned len_w
  );
    return (32'd1 << len_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rle_fifo.sv
// Synchronous show-ahead record FIFO; head word valid while not empty.
// Ports: CLK, reset, push/wdata, pop, rdata/valid, level, drop.
module rle_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_en;
  logic          push_en;
  logic          full;

  assign valid   = level != '0;
  assign full    = level == LVL_W'(DEPTH);
  assign pop_en  = valid && pop;
  // a same-edge pop frees the slot a full FIFO needs
  assign push_en = push && (!full || pop_en);
  assign drop    = push && !push_en;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_en, pop_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rle_stream_encoder.sv
// Per-line run-length encoder of a raster pixel stream into records.
// Ports: CLK, reset, in_valid/in_pixel, out_* record stream, status.
module rle_stream_encoder
  import rle_pkg::*;
#(
  parameter int IMAGE_W    = 640,
  parameter int PIX_W      = 1,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [PIX_W-1:0]                  in_pixel,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PIX_W-1:0]                  out_value,
  output logic [LEN_W-1:0]                  out_length,
  output logic                              out_eol,
  output logic                              line_start,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int COL_W = $clog2(IMAGE_W);
  localparam logic [LEN_W-1:0] RUN_MAX =
    LEN_W'(run_max(LEN_W));
  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(IMAGE_W-1);

  logic [COL_W-1:0] col;
  logic [PIX_W-1:0] run_val;
  logic [LEN_W-1:0] run_len;
  logic             pend_vld;
  logic [PIX_W-1:0] pend_val;

  logic             first;
  logic             last;
  logic             same;
  logic             enc_push;
  logic [LEN_W-1:0] enc_len;
  logic             enc_eol;
  logic             set_pend;

  logic             push;
  rle_rec_t         push_rec;
  rle_rec_t         head;
  logic             drop;
  logic             unused_hi;

  assign first = col == '0;
  assign last  = col == COL_LAST;
  assign same  = (in_pixel == run_val) && (run_len != RUN_MAX);

  always_comb begin
    enc_push = 1'b0;
    enc_len  = run_len;
    enc_eol  = 1'b0;
    set_pend = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        first: enc_push = 1'b0;
        last: begin
          enc_push = 1'b1;
          if (same) begin
            enc_len = run_len + LEN_W'(1);
            enc_eol = 1'b1;
          end else begin
            set_pend = 1'b1;
          end
        end
        default: enc_push = !same;
      endcase
    end
  end

  // the pending push lands on a column-0 edge or an idle edge,
  // neither of which produces an encoder push
  always_comb begin
    push_rec = '0;
    if (pend_vld) begin
      push_rec.value  = VAL_W_MAX'(pend_val);
      push_rec.length = LEN_W_MAX'(1);
      push_rec.eol    = 1'b1;
    end else begin
      push_rec.value  = VAL_W_MAX'(run_val);
      push_rec.length = LEN_W_MAX'(enc_len);
      push_rec.eol    = enc_eol;
    end
  end

  assign push = enc_push || pend_vld;

  always_ff @(posedge CLK) begin
    if (reset) begin
      col        <= '0;
      run_val    <= '0;
      run_len    <= '0;
      pend_vld   <= 1'b0;
      pend_val   <= '0;
      line_start <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      line_start <= in_valid && first;
      pend_vld   <= set_pend;
      overflow   <= overflow || drop;
      if (set_pend) pend_val <= in_pixel;
      if (in_valid) begin
        col <= last ? '0 : col + COL_W'(1);
        if (first || last || !same) begin
          run_val <= in_pixel;
          run_len <= LEN_W'(1);
        end else begin
          run_len <= run_len + LEN_W'(1);
        end
      end
    end
  end

  rle_fifo #(
    .W     ($bits(rle_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .wdata (push_rec),
    .pop   (out_ready),
    .rdata (head),
    .valid (out_valid),
    .level (fifo_level),
    .drop  (drop)
  );

  assign out_value  = head.value[PIX_W-1:0];
  assign out_length = head.length[LEN_W-1:0];
  assign out_eol    = head.eol;
  assign unused_hi  = |(head.value >> PIX_W) |
                      |(head.length >> LEN_W);

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Directed bench for rle_stream_encoder (8-pixel lines, 1-bit pixels).
// Records popped by the consumer are collected and compared.
module tb_rle_stream_encoder;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_pixel = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_value;
  logic [2:0] out_length;
  logic       out_eol;
  logic       line_start;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int ls_cnt = 0;
  logic [4:0] q[$];

  rle_stream_encoder #(
    .IMAGE_W    (8),
    .PIX_W      (1),
    .LEN_W      (3),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_length (out_length),
    .out_eol    (out_eol),
    .line_start (line_start),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (out_valid && out_ready)
      q.push_back({out_value, out_length, out_eol});
    if (line_start) ls_cnt++;
  end

  function automatic logic [4:0] rec(
    input logic v, input logic [2:0] l, input logic e
  );
    return {v, l, e};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic px(input logic b);
    in_valid = 1'b1;
    in_pixel = b;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_pixel = 1'b0;
  endtask

  task automatic send(input logic [7:0] l, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      px(l[i]);
      if (gaps) idle(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic zero_chk(input string tag);
    @(negedge CLK);
    chk({tag, "_vld"}, 32'(out_valid), 0);
    chk({tag, "_val"}, 32'(out_value), 0);
    chk({tag, "_len"}, 32'(out_length), 0);
    chk({tag, "_eol"}, 32'(out_eol), 0);
    chk({tag, "_ls"}, 32'(line_start), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_lvl"}, 32'(fifo_level), 0);
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    zero_chk("rst");

    q.delete(); ls_cnt = 0;
    send(8'b00011110, 1'b0);
    idle(6);
    chk("l1_n", q.size(), 3);
    chk("l1_r0", q[0], rec(0, 3, 0));
    chk("l1_r1", q[1], rec(1, 4, 0));
    chk("l1_r2", q[2], rec(0, 1, 1));
    chk("l1_ls", ls_cnt, 1);

    q.delete();
    send(8'b11111111, 1'b0);
    idle(6);
    chk("l2_n", q.size(), 2);
    chk("l2_r0", q[0], rec(1, 7, 0));
    chk("l2_r1", q[1], rec(1, 1, 1));

    q.delete();
    out_ready = 1'b0;
    send(8'b11111110, 1'b0);
    chk("l3_lvl_c7", 32'(fifo_level), 1);
    idle(1);
    chk("l3_lvl_pend", 32'(fifo_level), 2);
    out_ready = 1'b1;
    idle(5);
    chk("l3_n", q.size(), 2);
    chk("l3_r0", q[0], rec(1, 7, 0));
    chk("l3_r1", q[1], rec(0, 1, 1));

    q.delete();
    out_ready = 1'b0;
    send(8'b01010101, 1'b0);
    idle(2);
    @(negedge CLK);
    chk("ov_lvl", 32'(fifo_level), 4);
    chk("ov_flag", 32'(overflow), 1);
    chk("ov_head", {out_value, out_length, out_eol}, rec(0, 1, 0));
    idle(3);
    @(negedge CLK);
    chk("ov_hold", {out_value, out_length, out_eol}, rec(0, 1, 0));
    chk("ov_hold_vld", 32'(out_valid), 1);
    out_ready = 1'b1;
    idle(8);
    chk("ov_n", q.size(), 4);
    chk("ov_r0", q[0], rec(0, 1, 0));
    chk("ov_r1", q[1], rec(1, 1, 0));
    chk("ov_r2", q[2], rec(0, 1, 0));
    chk("ov_r3", q[3], rec(1, 1, 0));
    chk("ov_lvl0", 32'(fifo_level), 0);
    chk("ov_sticky", 32'(overflow), 1);

    px(1'b0); px(1'b1); px(1'b1);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    zero_chk("mid");
    q.delete(); ls_cnt = 0;
    send(8'b00000000, 1'b0);
    idle(6);
    chk("mr_n", q.size(), 2);
    chk("mr_r0", q[0], rec(0, 7, 0));
    chk("mr_r1", q[1], rec(0, 1, 1));
    chk("mr_ls", ls_cnt, 1);

    q.delete(); ls_cnt = 0;
    send(8'b00011110, 1'b1);
    idle(6);
    chk("gp_n", q.size(), 3);
    chk("gp_r0", q[0], rec(0, 3, 0));
    chk("gp_r1", q[1], rec(1, 4, 0));
    chk("gp_r2", q[2], rec(0, 1, 1));
    chk("gp_ls", ls_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
